// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word reads to a synchronous-read
// instruction memory, presents one instruction per cycle to decode, holds the
// presented instruction across decode stalls and restarts on redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_dout,
    output logic               if_valid,
    output logic [31:0]        if_inst,
    output logic [31:0]        if_pc
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        hold_valid_q, hold_valid_d;

    logic [31:0] issue_addr;
    logic [31:0] sel_inst;
    logic [31:0] sel_pc;

    // Issue address, read enable and the decode-facing output mux; reset forces a read at RESET_PC
    always_comb begin
        issue_addr = pc_q;
        if (rst) begin
            issue_addr = RESET_PC;
        end else if (redirect_valid) begin
            issue_addr = redirect_pc & ~32'd3;
        end
        imem_en   = rst | redirect_valid | ~stall | (state_q == BOOT);
        imem_addr = issue_addr[IMEM_AW+1:2];

        sel_inst = NOP;
        sel_pc   = rsp_pc_q;
        if (hold_valid_q) begin
            sel_inst = hold_inst_q;
            sel_pc   = hold_pc_q;
        end else if (rsp_valid_q) begin
            sel_inst = imem_dout;
        end

        if_valid = (hold_valid_q | rsp_valid_q) & ~redirect_valid & (state_q == RUN) & ~rst;
        if_inst  = if_valid ? sel_inst : NOP;
        if_pc    = sel_pc;
    end

    // Next-state: advance on every enabled read, capture/release the stall hold, BOOT lasts one cycle
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rsp_pc_d     = rsp_pc_q;
        rsp_valid_d  = rsp_valid_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        hold_valid_d = hold_valid_q;

        if (imem_en) begin
            pc_d        = issue_addr + 32'd4;
            rsp_pc_d    = issue_addr;
            rsp_valid_d = 1'b1;
        end

        if (redirect_valid) begin
            hold_valid_d = 1'b0;
        end else if (stall && !hold_valid_q && if_valid) begin
            hold_inst_d  = if_inst;
            hold_pc_d    = if_pc;
            hold_valid_d = 1'b1;
        end else if (!stall && hold_valid_q) begin
            hold_valid_d = 1'b0;
        end

        if (state_q == BOOT) begin
            state_d = RUN;
        end
    end

    // State registers with synchronous reset that discards any outstanding read and held instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            rsp_pc_q     <= RESET_PC;
            rsp_valid_q  <= 1'b0;
            hold_inst_q  <= NOP;
            hold_pc_q    <= RESET_PC;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rsp_pc_q     <= rsp_pc_d;
            rsp_valid_q  <= rsp_valid_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
            hold_valid_q <= hold_valid_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h4000_0000, byte address of the first fetch after reset.
REQ-002 Parameter: IMEM_AW, 14, instruction-memory word-address width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 stall  in  1  decode cannot accept the presented instruction this cycle.
REQ-006 redirect_valid  in  1  taken branch/jump resolved downstream; restart fetch at redirect_pc.
REQ-007 redirect_pc  in  32  redirect target byte address.
REQ-008 imem_en  out  1  instruction-memory read enable.
REQ-009 imem_addr  out  IMEM_AW  instruction-memory word address.
REQ-010 imem_dout  in  32  synchronous-read data; valid one cycle after an enabled read.
REQ-011 if_valid  out  1  if_inst/if_pc hold a live instruction for decode.
REQ-012 if_inst  out  32  instruction to decode; 32'h0000_0013 (NOP) whenever if_valid=0.
REQ-013 if_pc  out  32  byte address of if_inst.

Function
REQ-014 State: pc_reg (next address to issue), rsp_pc, rsp_valid (tracks the outstanding read), hold_inst/hold_pc/hold_valid (stall capture), FSM {BOOT, RUN}.
REQ-015 Issue address: redirect_valid=1 -> {redirect_pc[31:2],2'b00}; otherwise pc_reg; imem_addr = issue address bits [IMEM_AW+1:2].
REQ-016 imem_en = redirect_valid | ~stall | (state==BOOT).
REQ-017 Latency: an address issued with imem_en=1 in cycle t is presented on if_inst/if_pc in cycle t+1, unless killed or stalled.
REQ-018 When imem_en=1: pc_reg <= issue address + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000); rsp_pc <= issue address; rsp_valid <= 1.
REQ-019 When imem_en=0: pc_reg, rsp_pc and rsp_valid hold.
REQ-020 Output mux: hold_valid=1 -> hold_inst/hold_pc; else rsp_valid=1 -> imem_dout/rsp_pc; else NOP/rsp_pc.
REQ-021 if_valid = (hold_valid | rsp_valid) & ~redirect_valid & (state==RUN).
REQ-022 Stall capture: stall=1, redirect_valid=0, hold_valid=0 and a live output -> hold_inst/hold_pc <= presented values; hold_valid <= 1.
REQ-023 Stall release: stall=0 with hold_valid=1 -> decode consumes the hold value this cycle; hold_valid <= 0; the next sequential read issues this same cycle.
REQ-024 No instruction is dropped or duplicated across any stall length, including 1 cycle and back-to-back stalls.
REQ-025 Redirect: has priority over stall. The presented instruction is killed (if_valid=0). hold_valid <= 0. The target is read this cycle; inst(target) is valid next cycle, with zero extra bubbles.
REQ-026 Redirect on consecutive cycles: each cycle kills the current output; only the last target proceeds.
REQ-027 FSM: BOOT -> RUN after one cycle. In BOOT: imem_en=1 at pc_reg, if_valid=0, stall ignored. RUN persists until rst.

Reset
REQ-028 rst=1 at a clock edge, from any state: pc_reg=RESET_PC; rsp_valid=0; hold_valid=0; state=BOOT.
REQ-029 Reset values are visible the following cycle: if_valid=0, if_inst=NOP, if_pc=RESET_PC.
REQ-030 Reset overrides stall and redirect in the same cycle; any outstanding read is discarded.
REQ-031 With rst held: imem_en=1 at RESET_PC each cycle and if_valid=0.

Verification
REQ-032 Boot: release rst, no stall, mem[n]=n -> BOOT cycle if_valid=0; then if_pc 0x4000_0000, 0x4000_0004, ... each cycle with matching if_inst, no gaps.
REQ-033 Stall: stall=1 for 3 cycles while 0x4000_0008 is presented -> if_pc stays 0x4000_0008 with stable if_inst and imem_en=0; cycle after release presents 0x4000_000C.
REQ-034 Redirect: redirect_valid=1, redirect_pc=0x4000_0100 while stall=1 -> if_valid=0 that cycle; next cycle if_pc=0x4000_0100, if_valid=1; stalled instruction never reappears.
REQ-035 Misaligned/wrap: redirect_pc=0xFFFF_FFFE -> if_pc=0xFFFF_FFFC, then 0x0000_0000.
REQ-036 Reset mid-stall: rst=1 while hold_valid=1 -> next cycle if_valid=0, if_pc=RESET_PC; after release, fetch restarts at RESET_PC with no stale hold data.
